// File: rtl/fifo_tx_sched_if.sv
// Handshake bundle between the TX scheduler, its FIFO and the transmitter.
interface fifo_tx_sched_if;
  logic       fcr_wr;
  logic [7:0] fcr_din;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_en;
  logic       fifo_pop;
  logic       fifo_clr;
  logic [3:0] fifo_threshold;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       thre_irq;
  logic [7:0] tx_count;

  // Scheduler side
  modport master (
    input  fcr_wr, fcr_din, fifo_empty, fifo_dout, tx_ready,
    output fifo_en, fifo_pop, fifo_clr, fifo_threshold, tx_valid, tx_data, thre_irq, tx_count
  );

  // Environment side (FIFO, transmitter, register host)
  modport slave (
    output fcr_wr, fcr_din, fifo_empty, fifo_dout, tx_ready,
    input  fifo_en, fifo_pop, fifo_clr, fifo_threshold, tx_valid, tx_data, thre_irq, tx_count
  );
endinterface

// File: rtl/fifo_tx_sched.sv
// TX FIFO scheduler: moves bytes one at a time from the TX FIFO to the transmitter,
// owns the FIFO control register and raises the holding-register-empty indication.
module fifo_tx_sched (
  input logic             clk,
  input logic             rst,
  fifo_tx_sched_if.master bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPop     = 3'd1,
    StCapture = 3'd2,
    StSend    = 3'd3,
    StClear   = 3'd4
  } state_e;

  state_e     state_q;
  logic       fifo_en_q;
  logic [3:0] threshold_q;
  logic       pop_q;
  logic       clr_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic [7:0] tx_count_q;
  logic       thre_q;
  logic       thre_d;
  logic       clr_pend_q;
  logic       clr_pend_d;
  logic       clr_req;

  // Reserved FCR bits carry no meaning here
  logic unused_fcr_bits;
  assign unused_fcr_bits = ^{bus.fcr_din[5:3], bus.fcr_din[1]};

  assign clr_req = bus.fcr_wr & bus.fcr_din[2];

  function automatic logic [3:0] trig_level(input logic [1:0] code);
    logic [3:0] lvl;
    case (code)
      2'b00:   lvl = 4'd1;
      2'b01:   lvl = 4'd4;
      2'b10:   lvl = 4'd8;
      default: lvl = 4'd14;
    endcase
    return lvl;
  endfunction

  // FIFO control register: enable and trigger level update in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_en_q   <= 1'b0;
      threshold_q <= 4'd1;
    end else if (bus.fcr_wr) begin
      fifo_en_q   <= bus.fcr_din[0];
      threshold_q <= trig_level(bus.fcr_din[7:6]);
    end
  end

  // Clear-pending next state; a request landing while the pulse is already
  // being issued is absorbed by that same pulse
  always_comb begin
    clr_pend_d = clr_pend_q;
    if (state_q == StClear) begin
      clr_pend_d = 1'b0;
    end else if (clr_req) begin
      clr_pend_d = 1'b1;
    end
  end

  // Holding-register-empty condition, registered so it lags the state by one cycle
  always_comb begin
    thre_d = (state_q == StIdle) && bus.fifo_empty && !clr_pend_q;
  end

  // Clear-pending flag and THRE register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_pend_q <= 1'b0;
      thre_q     <= 1'b0;
    end else begin
      clr_pend_q <= clr_pend_d;
      thre_q     <= thre_d;
    end
  end

  // Transfer FSM with registered pop/clear/valid outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pop_q      <= 1'b0;
      clr_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_count_q <= 8'h00;
    end else begin
      pop_q <= 1'b0;
      clr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Clear wins over a new pop; pop only on a non-empty FIFO
          if (clr_pend_q) begin
            state_q <= StClear;
            clr_q   <= 1'b1;
          end else if (fifo_en_q && !bus.fifo_empty) begin
            state_q <= StPop;
            pop_q   <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StCapture;
        end
        StCapture: begin
          // FIFO read data is valid the cycle after the pop
          tx_data_q  <= bus.fifo_dout;
          tx_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_count_q <= tx_count_q + 8'd1;
            state_q    <= StIdle;
          end
        end
        StClear: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.fifo_en        = fifo_en_q;
  assign bus.fifo_threshold = threshold_q;
  assign bus.fifo_pop       = pop_q;
  assign bus.fifo_clr       = clr_q;
  assign bus.tx_valid       = tx_valid_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_count       = tx_count_q;
  assign bus.thre_irq       = thre_q;

endmodule
